// File: rtl/data_mem_ctrl.sv
// Data-memory controller: word-organised RAM with RV32I byte/half/word
// loads and stores, configurable wait states and misalignment/illegal detection.
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        stall,
  output logic        fault
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;

  stateT              state;
  logic [CNT_W-1:0]   waitCnt;
  logic               weQ;
  logic [2:0]         funct3Q;
  logic [IDX_W+1:0]   addrQ;
  logic [31:0]        wdataQ;

  logic [31:0]        mem [DEPTH_WORDS];

  logic               curWe;
  logic [2:0]         curFunct3;
  logic [IDX_W+1:0]   curAddr;
  logic [31:0]        curWdata;
  logic [IDX_W-1:0]   wordIdx;
  logic               enterDone;
  logic               illegal;
  logic               misaligned;
  logic               accFault;
  logic [3:0]         byteEn;
  logic [31:0]        laneData;
  logic [31:0]        memWord;
  logic [7:0]         loadByte;
  logic [15:0]        loadHalf;
  logic [31:0]        loadVal;
  logic               memWe;
  logic               unusedAddrBits;

  // Upper address bits alias onto the RAM and are deliberately ignored
  assign unusedAddrBits = ^addr[31:IDX_W+2];

  assign stall = req & ~ready;

  // Access attributes: live inputs while idle (zero-latency case), captured ones afterwards
  always_comb begin
    curWe     = weQ;
    curFunct3 = funct3Q;
    curAddr   = addrQ;
    curWdata  = wdataQ;
    if (state == IDLE) begin
      curWe     = we;
      curFunct3 = funct3;
      curAddr   = addr[IDX_W+1:0];
      curWdata  = wdata;
    end
  end

  assign wordIdx   = curAddr[IDX_W+1:2];
  assign enterDone = ((state == IDLE) && req && (LATENCY == 0)) ||
                     ((state == WAIT) && (waitCnt == CNT_W'(1)));

  // Legality, alignment, lane enables and store data replication
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    byteEn     = 4'b0000;
    laneData   = curWdata;
    if (curWe) illegal = curFunct3[2] || (curFunct3[1:0] == 2'b11);
    else       illegal = (curFunct3[1:0] == 2'b11) || (curFunct3 == 3'b110);
    case (curFunct3[1:0])
      2'b00: begin
        byteEn   = 4'b0001 << curAddr[1:0];
        laneData = {4{curWdata[7:0]}};
      end
      2'b01: begin
        misaligned = curAddr[0];
        byteEn     = curAddr[1] ? 4'b1100 : 4'b0011;
        laneData   = {2{curWdata[15:0]}};
      end
      2'b10: begin
        misaligned = (curAddr[1:0] != 2'b00);
        byteEn     = 4'b1111;
      end
      default: byteEn = 4'b0000;
    endcase
  end

  assign accFault = illegal | misaligned;
  assign memWe    = enterDone & curWe & ~accFault;
  assign memWord  = mem[wordIdx];

  // Lane selection and sign/zero extension of the load result
  always_comb begin
    loadByte = memWord[7:0];
    loadHalf = curAddr[1] ? memWord[31:16] : memWord[15:0];
    loadVal  = 32'd0;
    case (curAddr[1:0])
      2'b00:   loadByte = memWord[7:0];
      2'b01:   loadByte = memWord[15:8];
      2'b10:   loadByte = memWord[23:16];
      default: loadByte = memWord[31:24];
    endcase
    case (curFunct3)
      3'b000:  loadVal = {{24{loadByte[7]}}, loadByte};
      3'b001:  loadVal = {{16{loadHalf[15]}}, loadHalf};
      3'b010:  loadVal = memWord;
      3'b100:  loadVal = {24'd0, loadByte};
      3'b101:  loadVal = {16'd0, loadHalf};
      default: loadVal = 32'd0;
    endcase
  end

  // Byte-lane RAM write on the edge entering DONE; contents are never reset
  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[wordIdx][8*i +: 8] <= laneData[8*i +: 8];
      end
    end
  end

  // Access sequencing, request capture and registered completion outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      waitCnt <= '0;
      weQ     <= 1'b0;
      funct3Q <= 3'd0;
      addrQ   <= '0;
      wdataQ  <= 32'd0;
      rdata   <= 32'd0;
      ready   <= 1'b0;
      fault   <= 1'b0;
    end else begin
      ready <= enterDone;
      fault <= enterDone & accFault;
      if (enterDone && (!curWe || accFault)) rdata <= accFault ? 32'd0 : loadVal;
      case (state)
        IDLE: begin
          if (req) begin
            weQ     <= we;
            funct3Q <= funct3;
            addrQ   <= addr[IDX_W+1:0];
            wdataQ  <= wdata;
            waitCnt <= CNT_W'(LATENCY);
            state   <= (LATENCY == 0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          waitCnt <= waitCnt - CNT_W'(1);
          if (waitCnt == CNT_W'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: four configurations, directed and random accesses,
// byte-level reference memory and a queue-based scoreboard per instance.
module tb_data_mem_ctrl;

  typedef struct {
    logic        isStore;
    logic        flt;
    logic [31:0] rd;
  } expT;

  logic clk;
  int   errors  = 0;
  int   checks  = 0;
  int   doneCnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int cfg, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cfg%0d: got %h expected %h at %0t", nm, cfg, act, expv, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : gCfg
    localparam int L = (g == 0) ? 2 : (g == 1) ? 0 : (g == 2) ? 3 : 1;
    localparam int D = (g == 3) ? 16 : 1024;

    logic        rstN, req, we, ready, stall, fault;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata;
    byte unsigned mdl [4*D];
    expT         q [$];

    data_mem_ctrl #(.DEPTH_WORDS(D), .LATENCY(L)) dut (
      .clk(clk), .rst_n(rstN), .req(req), .we(we), .funct3(funct3),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
      .stall(stall), .fault(fault)
    );

    // Reference: byte-addressed memory, RV32I legality and extension rules
    function automatic void model(input logic w, input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] d, output logic flt, output logic [31:0] rd);
      int size, b, sh;
      logic legal;
      logic [31:0] v;
      legal = w ? (f inside {3'd0, 3'd1, 3'd2}) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      size  = 1 << f[1:0];
      flt   = !legal || ((a & 32'(size - 1)) != 0);
      rd    = 32'd0;
      b     = int'(a & 32'(4*D - 1));
      if (!flt) begin
        if (w) begin
          for (int i = 0; i < size; i++) mdl[b+i] = d[8*i +: 8];
        end else begin
          v = 32'd0;
          for (int i = 0; i < size; i++) v = v | (32'(mdl[b+i]) << (8*i));
          sh = 32 - 8*size;
          if (!f[2] && size < 4) v = 32'($signed(v << sh) >>> sh);
          rd = v;
        end
      end
    endfunction

    // Issue one access, queue its expected response, check completion latency
    task automatic access(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
      expT e;
      int k;
      logic got;
      model(w, f, a, d, e.flt, e.rd);
      e.isStore = w;
      q.push_back(e);
      we = w; funct3 = f; addr = a; wdata = d; req = 1'b1;
      k = 0; got = 1'b0;
      while (!got && k < 20) begin
        @(negedge clk);
        if (ready) got = 1'b1;
        else begin
          k++;
          if (k >= 2 && $urandom_range(0, 1) == 1) begin
            we = ~we; funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
          end
        end
      end
      chk("latency", g, 32'(k), 32'(L + 1));
      @(posedge clk);
      #1 req = 1'b0;
    endtask

    // Scoreboard monitor: completion data, fault pulse, rdata hold and stall
    logic [31:0] lastR = 32'd0;
    expT         me;
    logic [31:0] expR;
    always @(negedge clk) begin
      if (!rstN) lastR = 32'd0;
      else begin
        chk("stall", g, 32'(stall), 32'(req & ~ready));
        if (ready) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ready cfg%0d: got ready 1 expected no pending access", g);
          end else begin
            me   = q.pop_front();
            expR = (me.isStore && !me.flt) ? lastR : me.rd;
            chk("rdata", g, rdata, expR);
            chk("fault", g, 32'(fault), 32'(me.flt));
            if (!me.isStore || me.flt) lastR = me.rd;
          end
        end else begin
          chk("rdata_hold", g, rdata, lastR);
          chk("fault_idle", g, 32'(fault), 32'd0);
        end
      end
    end

    // Driver: reset, memory init, directed cases per configuration, random traffic
    initial begin
      logic [31:0] r;
      for (int i = 0; i < 4*D; i++) mdl[i] = 8'd0;
      rstN = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1 rstN = 1'b1;
      @(negedge clk);
      chk("reset_ready", g, 32'(ready), 32'd0);
      chk("reset_rdata", g, rdata, 32'd0);
      @(posedge clk);
      #1;
      for (int w = 0; w < 32; w++) access(1'b1, 3'd2, 32'(w * 4), 32'd0);

      if (g == 0) begin
        access(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        access(1'b0, 3'd2, 32'h10, 32'h0);
        access(1'b1, 3'd2, 32'h10, 32'h11223344);
        access(1'b1, 3'd0, 32'h12, 32'h000000A5);
        access(1'b0, 3'd0, 32'h12, 32'h0);
        access(1'b0, 3'd4, 32'h12, 32'h0);
        access(1'b0, 3'd2, 32'h10, 32'h0);
        access(1'b0, 3'd1, 32'h11, 32'h0);
        access(1'b1, 3'd2, 32'h0E, 32'hFFFFFFFF);
        access(1'b0, 3'd2, 32'h0C, 32'h0);
        access(1'b0, 3'd2, 32'h10, 32'h0);
        access(1'b0, 3'd3, 32'h10, 32'h0);
        access(1'b1, 3'd4, 32'h10, 32'h55555555);
        access(1'b0, 3'd2, 32'h10, 32'h0);
      end else if (g == 1) begin
        access(1'b1, 3'd1, 32'h22, 32'h00008001);
        access(1'b0, 3'd1, 32'h22, 32'h0);
        access(1'b0, 3'd5, 32'h22, 32'h0);
      end else if (g == 2) begin
        access(1'b1, 3'd2, 32'h44, 32'h55AA55AA);
        access(1'b0, 3'd2, 32'h44, 32'h0);
        we = 1'b1; funct3 = 3'd2; addr = 32'h40; wdata = 32'h12345678; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
          chk("abort_ready", g, 32'(ready), 32'd0);
          chk("abort_fault", g, 32'(fault), 32'd0);
          chk("abort_rdata", g, rdata, 32'd0);
          @(negedge clk);
        end
        req = 1'b0;
        @(posedge clk);
        #1 rstN = 1'b1;
        access(1'b0, 3'd2, 32'h40, 32'h0);
      end else begin
        access(1'b1, 3'd2, 32'h44, 32'hCAFEF00D);
        access(1'b0, 3'd2, 32'h04, 32'h0);
      end

      repeat (60) begin
        r = $urandom;
        access(1'($urandom), 3'($urandom), (r & 32'hFFFFF000) | 32'($urandom_range(0, 127)), $urandom);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      repeat (3) @(posedge clk);
      chk("queue_drained", g, 32'(q.size()), 32'd0);
      doneCnt++;
    end
  end

  // Wait for all configurations with a bounded cycle budget, then summarise
  initial begin
    for (int i = 0; i < 90000 && doneCnt < 4; i++) @(posedge clk);
    if (doneCnt < 4) begin
      checks++; errors++;
      $display("FAIL timeout: got %0d finished configs expected 4", doneCnt);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
